// File: rtl/reset_sequencer.sv
// Staged system reset: holds peripheral and CPU resets until the PLL lock is stable,
// then releases peripherals first and the CPU a fixed gap later; records the last cause.
module reset_sequencer #(
  parameter int unsigned             pTimerWidth = 16,
  parameter logic [pTimerWidth-1:0]  pHoldCycles = 16'd50_000,
  parameter logic [pTimerWidth-1:0]  pStageGap   = 16'd1_000
) (
  input  logic       gClock,
  input  logic       gReset,
  input  logic       iButtonPulse,
  input  logic       iSoftReset,
  input  logic       iPllLocked,
  output logic       oRstPeriph,
  output logic       oRstCpu,
  output logic       oReady,
  output logic [1:0] oCause
);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    GAP  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_POR    = 2'b00;
  localparam logic [1:0] CAUSE_BUTTON = 2'b01;
  localparam logic [1:0] CAUSE_SOFT   = 2'b10;
  localparam logic [1:0] CAUSE_LOCK   = 2'b11;

  state_t                 state_q, state_d;
  logic [pTimerWidth-1:0] timer_q, timer_d;
  logic [1:0]             cause_q, cause_d;
  logic                   lock_meta_q, lock_q;
  logic                   rst_periph_q, rst_cpu_q, ready_q;
  logic                   lock_loss;
  logic                   trigger;

  // Lock loss only counts once the sequence has left HOLD; in HOLD it just restarts the wait.
  assign lock_loss = !lock_q && (state_q != HOLD);
  assign trigger   = lock_loss || iButtonPulse || iSoftReset;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cause_d = cause_q;
    if (trigger) begin
      state_d = HOLD;
      timer_d = pHoldCycles;
      if (lock_loss)
        cause_d = CAUSE_LOCK;
      else if (iButtonPulse)
        cause_d = CAUSE_BUTTON;
      else
        cause_d = CAUSE_SOFT;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (!lock_q) begin
            timer_d = pHoldCycles;
          end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else begin
            state_d = GAP;
            timer_d = pStageGap;
          end
        end
        GAP: begin
          if (timer_q != '0)
            timer_d = timer_q - 1'b1;
          else
            state_d = RUN;
        end
        RUN: begin
          timer_d = timer_q;
        end
        default: begin
          state_d = HOLD;
          timer_d = pHoldCycles;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they always match the state register.
  always_ff @(posedge gClock or posedge gReset) begin
    if (gReset) begin
      lock_meta_q  <= 1'b0;
      lock_q       <= 1'b0;
      state_q      <= HOLD;
      timer_q      <= pHoldCycles;
      cause_q      <= CAUSE_POR;
      rst_periph_q <= 1'b1;
      rst_cpu_q    <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      lock_meta_q  <= iPllLocked;
      lock_q       <= lock_meta_q;
      state_q      <= state_d;
      timer_q      <= timer_d;
      cause_q      <= cause_d;
      rst_periph_q <= (state_d == HOLD);
      rst_cpu_q    <= (state_d != RUN);
      ready_q      <= (state_d == RUN);
    end
  end

  assign oRstPeriph = rst_periph_q;
  assign oRstCpu    = rst_cpu_q;
  assign oReady     = ready_q;
  assign oCause     = cause_q;

endmodule
